bfp_denormalizer: RTL and testbench

//  Inverse of the BFP normalizer: takes block-scaled I/Q mantissas plus a per-block exponent and

---
 rtl/bfp_denormalizer.sv | 121 ++++++++++++
 tb/tb_bfp_denormalizer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfp_denormalizer.sv
// bfp_denormalizer: restores fixed-point I/Q samples from block-floating-point mantissas and checks block framing.
// Optional macro BFP_DENORM_ROUND_EN selects round-half-up; without it the shift truncates (floor).
module bfp_denormalizer #(
    parameter int DATA_W    = 16,
    parameter int EXP_W     = 4,
    parameter int BLOCK_LEN = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_in,
    input  logic [DATA_W-1:0] q_in,
    input  logic [EXP_W-1:0]  exponent_in,
    input  logic              valid_in,
    input  logic              last_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] i_out,
    output logic [DATA_W-1:0] q_out,
    output logic              last_out,
    output logic              valid_out,
    input  logic              ready_out,
    output logic              err_short,
    output logic              err_long,
    output logic              err_exp
);

    localparam int CNT_W = $clog2(BLOCK_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic {IDLE, BLOCK} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [EXP_W-1:0]  exp_lat;
    logic              accept;
    logic [EXP_W-1:0]  shift;
    logic [DATA_W-1:0] i_shifted;
    logic [DATA_W-1:0] q_shifted;

    function automatic logic [DATA_W-1:0] restore(input logic [DATA_W-1:0] x,
                                                  input logic [EXP_W-1:0]  s);
        logic signed [DATA_W-1:0] xs;
        logic signed [DATA_W-1:0] floor_val;
`ifdef BFP_DENORM_ROUND_EN
        logic signed [DATA_W-1:0] half;
`endif
        xs        = signed'(x);
        floor_val = xs >>> s;
`ifdef BFP_DENORM_ROUND_EN
        // Bit s-1 of the mantissa is the half-LSB that decides rounding up.
        half = xs >>> (s - 1'b1);
        if (s == '0)
            return x;
        else if (32'(s) >= DATA_W)
            return '0;
        else
            return floor_val + {{(DATA_W-1){1'b0}}, half[0]};
`else
        return floor_val;
`endif
    endfunction

    assign ready_in = !valid_out || ready_out;

    always_comb begin
        accept    = valid_in && ready_in;
        shift     = (state == IDLE) ? exponent_in : exp_lat;
        i_shifted = restore(i_in, shift);
        q_shifted = restore(q_in, shift);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            exp_lat   <= '0;
            i_out     <= '0;
            q_out     <= '0;
            last_out  <= 1'b0;
            valid_out <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            err_exp   <= 1'b0;
        end else begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            err_exp   <= 1'b0;
            if (accept) begin
                valid_out <= 1'b1;
                i_out     <= i_shifted;
                q_out     <= q_shifted;
                if (state == IDLE) begin
                    exp_lat <= exponent_in;
                    if (last_in) begin
                        // A one-beat block is always too short.
                        err_short <= 1'b1;
                        last_out  <= 1'b1;
                    end else begin
                        last_out <= 1'b0;
                        cnt      <= CNT_W'(1);
                        state    <= BLOCK;
                    end
                end else begin
                    err_exp <= (exponent_in != exp_lat);
                    if (last_in || cnt == LAST_CNT) begin
                        last_out  <= 1'b1;
                        err_short <= last_in && (cnt != LAST_CNT);
                        err_long  <= !last_in;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        last_out <= 1'b0;
                        cnt      <= cnt + 1'b1;
                    end
                end
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bfp_denormalizer.sv
// tb_bfp_denormalizer: directed self-checking bench for bfp_denormalizer.
// Expected values are hand-computed for both the truncating and BFP_DENORM_ROUND_EN builds.
module tb_bfp_denormalizer;

    logic        clk;
    logic        rst_n;
    logic [15:0] i_in;
    logic [15:0] q_in;
    logic [3:0]  exponent_in;
    logic        valid_in;
    logic        last_in;
    logic        ready_in;
    logic [15:0] i_out;
    logic [15:0] q_out;
    logic        last_out;
    logic        valid_out;
    logic        ready_out;
    logic        err_short;
    logic        err_long;
    logic        err_exp;

    int vectors     = 0;
    int miscompares = 0;

    logic [36:0] obs;
    assign obs = {valid_out, i_out, q_out, last_out, err_short, err_long, err_exp};

    localparam logic [15:0] PAT_IN  [8] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0020,
                                            16'h001F, 16'hFFE0, 16'h1234, 16'hEDCC};
`ifdef BFP_DENORM_ROUND_EN
    localparam logic [15:0] PAT_OUT [8] = '{16'h0400, 16'hFC00, 16'h0000, 16'h0001,
                                            16'h0001, 16'hFFFF, 16'h0092, 16'hFF6E};
    localparam logic [15:0] RND_OUT [6] = '{16'h0002, 16'hFFFF, 16'h0001, 16'h1234,
                                            16'h0000, 16'h0003};
`else
    localparam logic [15:0] PAT_OUT [8] = '{16'h03FF, 16'hFC00, 16'hFFFF, 16'h0001,
                                            16'h0000, 16'hFFFF, 16'h0091, 16'hFF6E};
    localparam logic [15:0] RND_OUT [6] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h1234,
                                            16'hFFFF, 16'h0002};
`endif
    localparam logic [15:0] RND_IN  [6] = '{16'h0006, 16'h8000, 16'h7FFF, 16'h1234,
                                            16'hFFFF, 16'h0005};
    localparam logic [3:0]  RND_EXP [6] = '{4'd2, 4'd15, 4'd15, 4'd0, 4'd1, 4'd1};

    bfp_denormalizer #(.DATA_W(16), .EXP_W(4), .BLOCK_LEN(256)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in        (i_in),
        .q_in        (q_in),
        .exponent_in (exponent_in),
        .valid_in    (valid_in),
        .last_in     (last_in),
        .ready_in    (ready_in),
        .i_out       (i_out),
        .q_out       (q_out),
        .last_out    (last_out),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .err_short   (err_short),
        .err_long    (err_long),
        .err_exp     (err_exp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one beat at the falling edge and returns just after the edge that accepts it.
    task automatic beat(input logic [15:0] i, input logic [15:0] q,
                        input logic [3:0] e, input logic l);
        @(negedge clk);
        i_in        = i;
        q_in        = q;
        exponent_in = e;
        last_in     = l;
        valid_in    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        valid_in = 1'b0;
        last_in  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_in  = 1'b0;
        last_in   = 1'b0;
        ready_out = 1'b1;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        i_in        = '0;
        q_in        = '0;
        exponent_in = '0;
        valid_in    = 1'b0;
        last_in     = 1'b0;
        ready_out   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs !== 37'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, 37'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        beat(16'h0010, 16'hFFF0, 4'd2, 1'b0);
        vectors++;
        if (obs !== {1'b1, 16'h0004, 16'hFFFC, 1'b0, 3'b000}) begin
            miscompares++;
            $display("[TB] FAIL reset_first_beat: got %h expected %h", obs,
                     {1'b1, 16'h0004, 16'hFFFC, 1'b0, 3'b000});
        end
        beat(16'h0010, 16'hFFF0, 4'd2, 1'b0);
        @(negedge clk);
        i_in = 16'h0010;
        valid_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 37'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_async_clear: got %h expected %h", obs, 37'h0);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (obs !== 37'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_held: got %h expected %h", obs, 37'h0);
        end
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b1;
        beat(16'h0100, 16'hFF00, 4'd4, 1'b0);
        vectors++;
        if (obs !== {1'b1, 16'h0010, 16'hFFF0, 1'b0, 3'b000}) begin
            miscompares++;
            $display("[TB] FAIL reset_new_exponent: got %h expected %h", obs,
                     {1'b1, 16'h0010, 16'hFFF0, 1'b0, 3'b000});
        end
        beat(16'h0100, 16'hFF00, 4'd4, 1'b0);
        vectors++;
        if (obs !== {1'b1, 16'h0010, 16'hFFF0, 1'b0, 3'b000}) begin
            miscompares++;
            $display("[TB] FAIL reset_latched_exponent: got %h expected %h", obs,
                     {1'b1, 16'h0010, 16'hFFF0, 1'b0, 3'b000});
        end
    endtask

    task automatic test_nominal();
        logic [36:0] expv;
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            beat(16'h0008, 16'hFFF8, 4'd3, k == 256);
            expv = {1'b1, 16'h0001, 16'hFFFF, k == 256, 3'b000};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL nominal beat %0d: got %h expected %h", k, obs, expv);
            end
        end
        idle();
        vectors++;
        if (valid_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL nominal_drain: valid_out got %b expected 0", valid_out);
        end
    endtask

    task automatic test_patterns();
        logic [36:0] expv;
        do_reset();
        for (int k = 0; k < 256; k++) begin
            if (k < 8) begin
                beat(PAT_IN[k], PAT_IN[7-k], 4'd5, 1'b0);
                expv = {1'b1, PAT_OUT[k], PAT_OUT[7-k], 1'b0, 3'b000};
            end else begin
                beat(16'h0000, 16'h0000, 4'd5, k == 255);
                expv = {1'b1, 16'h0000, 16'h0000, k == 255, 3'b000};
            end
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL patterns beat %0d: got %h expected %h", k + 1, obs, expv);
            end
        end
    endtask

    task automatic test_exp_change();
        logic [36:0] expv;
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            beat(16'h0040, 16'hFFC0, (k == 10) ? 4'd5 : 4'd3, k == 256);
            expv = {1'b1, 16'h0008, 16'hFFF8, k == 256, 2'b00, k == 10};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL exp_change beat %0d: got %h expected %h", k, obs, expv);
            end
        end
    endtask

    task automatic test_short();
        logic [36:0] expv;
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            beat(16'h0124, 16'hFEDC, 4'd1, k == 100);
            expv = {1'b1, 16'h0092, 16'hFF6E, k == 100, k == 100, 2'b00};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL short beat %0d: got %h expected %h", k, obs, expv);
            end
        end
        beat(16'h0100, 16'h0000, 4'd4, 1'b0);
        vectors++;
        if (obs !== {1'b1, 16'h0010, 16'h0000, 1'b0, 3'b000}) begin
            miscompares++;
            $display("[TB] FAIL short_restart: got %h expected %h", obs,
                     {1'b1, 16'h0010, 16'h0000, 1'b0, 3'b000});
        end
    endtask

    task automatic test_long();
        logic [36:0] expv;
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            beat(16'h0100, 16'hFF00, 4'd2, 1'b0);
            expv = {1'b1, 16'h0040, 16'hFFC0, k == 256, 1'b0, k == 256, 1'b0};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL long beat %0d: got %h expected %h", k, obs, expv);
            end
        end
        beat(16'h0100, 16'hFF00, 4'd6, 1'b0);
        vectors++;
        if (obs !== {1'b1, 16'h0004, 16'hFFFC, 1'b0, 3'b000}) begin
            miscompares++;
            $display("[TB] FAIL long_restart: got %h expected %h", obs,
                     {1'b1, 16'h0004, 16'hFFFC, 1'b0, 3'b000});
        end
    endtask

    task automatic test_rounding();
        for (int k = 0; k < 6; k++) begin
            do_reset();
            beat(RND_IN[k], 16'h0000, RND_EXP[k], 1'b0);
            vectors++;
            if (obs !== {1'b1, RND_OUT[k], 16'h0000, 1'b0, 3'b000}) begin
                miscompares++;
                $display("[TB] FAIL rounding vec %0d: got %h expected %h", k, obs,
                         {1'b1, RND_OUT[k], 16'h0000, 1'b0, 3'b000});
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent    = 0;
        int rcvd    = 0;
        int cycles  = 0;
        logic pending = 1'b0;
        logic acc;
        logic stall;
        logic take;
        logic [32:0] snap;
        do_reset();
        while (rcvd < 256 && cycles < 4000) begin
            cycles++;
            @(negedge clk);
            ready_out = 1'($urandom_range(0, 1));
            if (!pending) begin
                if (sent < 256) begin
                    i_in        = 16'(sent);
                    q_in        = ~16'(sent);
                    exponent_in = 4'd0;
                    last_in     = (sent == 255);
                    valid_in    = 1'b1;
                    pending     = 1'b1;
                end else begin
                    valid_in = 1'b0;
                    last_in  = 1'b0;
                end
            end
            #1;
            acc   = valid_in && ready_in;
            stall = valid_out && !ready_out;
            take  = valid_out && ready_out;
            snap  = {i_out, q_out, last_out};
            if (stall) begin
                vectors++;
                if (ready_in !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL bp_ready_in: got %b expected 0", ready_in);
                end
            end
            @(posedge clk);
            #1;
            if (take) begin
                vectors++;
                if (snap !== {16'(rcvd), ~16'(rcvd), rcvd == 255}) begin
                    miscompares++;
                    $display("[TB] FAIL bp_data beat %0d: got %h expected %h", rcvd, snap,
                             {16'(rcvd), ~16'(rcvd), rcvd == 255});
                end
                rcvd++;
            end
            if (stall) begin
                vectors++;
                if ({valid_out, i_out, q_out, last_out} !== {1'b1, snap}) begin
                    miscompares++;
                    $display("[TB] FAIL bp_hold: got %h expected %h",
                             {valid_out, i_out, q_out, last_out}, {1'b1, snap});
                end
            end
            if (acc) begin
                sent++;
                pending = 1'b0;
            end
        end
        vectors++;
        if (rcvd != 256) begin
            miscompares++;
            $display("[TB] FAIL bp_timeout: received %0d beats expected 256", rcvd);
        end
        @(negedge clk);
        valid_in  = 1'b0;
        last_in   = 1'b0;
        ready_out = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_patterns();
        test_exp_change();
        test_short();
        test_long();
        test_rounding();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
